// File: rtl/mmio_led_ctrl_if.sv
// mmio_led_ctrl_if: CPU data-bus view of the LED peripheral.
//   daddr    : CPU data address (big-endian word view)
//   din      : CPU store data
//   MemWrite : store strobe, qualified by hit inside the peripheral
//   hit      : address falls in the peripheral's 16-byte window (combinational)
//   rdata    : combinational read data, 0 when !hit
// master drives address/data/strobe (CPU side); slave is the peripheral.
interface mmio_led_ctrl_if;
  logic [31:0] daddr;
  logic [31:0] din;
  logic        MemWrite;
  logic        hit;
  logic [31:0] rdata;

  modport master (
    output daddr,
    output din,
    output MemWrite,
    input  hit,
    input  rdata
  );

  modport slave (
    input  daddr,
    input  din,
    input  MemWrite,
    output hit,
    output rdata
  );
endinterface

// File: rtl/mmio_led_ctrl.sv
// mmio_led_ctrl: memory-mapped LED peripheral on the CPU data bus.
//   Four word registers at BASE_ADDR (CTRL, PERIOD, DUTY, STATUS) drive
//   led_r/led_g with an 8-bit PWM per colour and an optional shared blink
//   that alternates red and green.
// Ports:
//   sys_clk   : clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : CPU data-bus slave (daddr, din, MemWrite in; hit, rdata out)
//   led_r     : red LED drive, active high, registered
//   led_g     : green LED drive, active high, registered
module mmio_led_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned CNT_W     = 24
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  mmio_led_ctrl_if.slave        bus,
  output logic                  led_r,
  output logic                  led_g
);

  // CTRL bits held in ctrl_q: [0] r_en, [1] g_en, [2] blink_en
  logic [2:0]       ctrl_q,       ctrl_d;
  logic [CNT_W-1:0] period_q,     period_d;
  logic [15:0]      duty_q,       duty_d;
  logic [7:0]       pwm_cnt_q,    pwm_cnt_d;
  logic [CNT_W-1:0] blink_cnt_q,  blink_cnt_d;
  logic             phase_q,      phase_d;
  logic [15:0]      toggle_cnt_q, toggle_cnt_d;
  logic             led_r_q,      led_r_d;
  logic             led_g_q,      led_g_d;

  logic       hit;
  logic       wr_en;
  logic [1:0] sel;
  logic       phase_clr;
  logic       on_r;
  logic       on_g;
  logic       blink_en;

  always_comb begin
    hit      = (bus.daddr[31:4] == BASE_ADDR[31:4]);
    wr_en    = hit && bus.MemWrite;
    sel      = bus.daddr[3:2];
    blink_en = ctrl_q[2];

    ctrl_d    = ctrl_q;
    period_d  = period_q;
    duty_d    = duty_q;
    phase_clr = 1'b0;
    if (wr_en) begin
      case (sel)
        2'd0: begin
          ctrl_d    = bus.din[2:0];
          phase_clr = bus.din[3];
        end
        2'd1:    period_d = bus.din[CNT_W-1:0];
        2'd2:    duty_d   = bus.din[15:0];
        default: ;
      endcase
    end

    pwm_cnt_d = pwm_cnt_q + 8'd1;

    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    toggle_cnt_d = toggle_cnt_q;
    if (blink_en && (period_q != '0)) begin
      // A PERIOD write at or below the running count would let the counter
      // run past PERIOD-1; restart it silently instead of toggling.
      if (blink_cnt_q >= period_q) begin
        blink_cnt_d = '0;
      end else if (blink_cnt_q == period_q - CNT_W'(1)) begin
        blink_cnt_d  = '0;
        phase_d      = ~phase_q;
        toggle_cnt_d = toggle_cnt_q + 16'd1;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
    // phase_clr wins over a toggle landing on the same edge.
    if (phase_clr) begin
      blink_cnt_d  = '0;
      phase_d      = 1'b0;
      toggle_cnt_d = toggle_cnt_q;
    end

    on_r    = ctrl_q[0] && (pwm_cnt_q < duty_q[7:0]);
    on_g    = ctrl_q[1] && (pwm_cnt_q < duty_q[15:8]);
    led_r_d = on_r && (!blink_en || !phase_q);
    led_g_d = on_g && (!blink_en ||  phase_q);
  end

  always_comb begin
    bus.hit   = hit;
    bus.rdata = '0;
    if (hit) begin
      case (sel)
        2'd0:    bus.rdata[2:0]       = ctrl_q;
        2'd1:    bus.rdata[CNT_W-1:0] = period_q;
        2'd2:    bus.rdata[15:0]      = duty_q;
        default: bus.rdata[16:0]      = {phase_q, toggle_cnt_q};
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ctrl_q       <= '0;
      period_q     <= '0;
      duty_q       <= '0;
      pwm_cnt_q    <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      toggle_cnt_q <= '0;
      led_r_q      <= 1'b0;
      led_g_q      <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      pwm_cnt_q    <= pwm_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      toggle_cnt_q <= toggle_cnt_d;
      led_r_q      <= led_r_d;
      led_g_q      <= led_g_d;
    end
  end

  assign led_r = led_r_q;
  assign led_g = led_g_q;

endmodule
